// File: rtl/rfbw_regfile_pkg.sv
// Shared types for the rfbw register file: data value, register address and sweep state.
package rfBlackWidowPkg;

  localparam int ValueW     = 32;
  localparam int RegAddrW   = 6;
  localparam int NumWrSlots = 3;

  typedef logic [ValueW-1:0]   Value;
  typedef logic [RegAddrW-1:0] reg_addr_t;

  typedef enum logic {
    StClear,
    StRun
  } rf_state_e;

endpackage

// File: rtl/rfbw_wr_arb.sv
// Resolves the three writeback slots into per-slot commit enables.
// Writes to r0 are dropped; on an address clash the higher-numbered slot wins.
module rfbw_wr_arb
  import rfBlackWidowPkg::*;
(
  input  logic [NumWrSlots-1:0] wr_i,
  input  reg_addr_t             wa_i [NumWrSlots],
  output logic [NumWrSlots-1:0] commit_o
);

  always_comb begin
    commit_o = '0;
    for (int s = 0; s < NumWrSlots; s++) begin
      commit_o[s] = wr_i[s] && (wa_i[s] != '0);
      // Any enabled younger slot to the same register kills this one.
      for (int h = s + 1; h < NumWrSlots; h++) begin
        if (wr_i[h] && (wa_i[h] == wa_i[s])) begin
          commit_o[s] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rfbw_regfile.sv
// Three-write, NRD-read register file with a post-reset zeroing sweep.
// Optional same-cycle write-to-read bypass when RFBW_RF_BYPASS_EN is defined.
module rfbw_regfile
  import rfBlackWidowPkg::*;
#(
  parameter int unsigned NRD  = 4,
  parameter int unsigned NREG = 64
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      wr0_i,
  input  logic      wr1_i,
  input  logic      wr2_i,
  input  reg_addr_t wa0_i,
  input  reg_addr_t wa1_i,
  input  reg_addr_t wa2_i,
  input  Value      wd0_i,
  input  Value      wd1_i,
  input  Value      wd2_i,
  input  reg_addr_t ra_i [NRD],
  output Value      rd_o [NRD],
  output logic      rdy_o
);

  localparam reg_addr_t LastIdx = reg_addr_t'(NREG - 1);

  rf_state_e state_q, state_d;
  reg_addr_t cnt_q, cnt_d;

  Value mem_q [NREG];

  logic [NumWrSlots-1:0] wr_vec;
  logic [NumWrSlots-1:0] commit_raw;
  logic [NumWrSlots-1:0] commit;
  reg_addr_t             wa_arr [NumWrSlots];
  Value                  wd_arr [NumWrSlots];

  assign wr_vec    = {wr2_i, wr1_i, wr0_i};
  assign wa_arr[0] = wa0_i;
  assign wa_arr[1] = wa1_i;
  assign wa_arr[2] = wa2_i;
  assign wd_arr[0] = wd0_i;
  assign wd_arr[1] = wd1_i;
  assign wd_arr[2] = wd2_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (cnt_q == LastIdx) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdy_o = (state_q == StRun);

  rfbw_wr_arb u_wr_arb (
    .wr_i     (wr_vec),
    .wa_i     (wa_arr),
    .commit_o (commit_raw)
  );

  // Write ports are inert until the sweep has finished.
  assign commit = commit_raw & {NumWrSlots{rdy_o}};

  // Array has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk_i) begin
    if (state_q == StClear) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int s = 0; s < NumWrSlots; s++) begin
        if (commit[s]) begin
          mem_q[wa_arr[s]] <= wd_arr[s];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    Value rd_val;
    always_comb begin
      rd_val = mem_q[ra_i[i]];
`ifdef RFBW_RF_BYPASS_EN
      // commit is already one-hot per address, so scan order does not matter.
      for (int s = 0; s < NumWrSlots; s++) begin
        if (commit[s] && (wa_arr[s] == ra_i[i])) begin
          rd_val = wd_arr[s];
        end
      end
`endif
      if (ra_i[i] == '0) begin
        rd_val = '0;
      end
    end
    assign rd_o[i] = rd_val;
  end

endmodule
